ace_sram_pager: RTL and testbench
=================================

ACE_SRAM_PAGER -- requirements
Module: ace_sram_pager

Interface
REQ-001 SHALL have parameter SRAM_AW, default 21, external SRAM address width.
REQ-002 SHALL have parameter WIN_BITS, default 14, log2 of window size; NWIN = 2^(16-WIN_BITS) windows; PAGE_W = SRAM_AW-WIN_BITS, legal range 1..7.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, SRAM wait states, legal range 0..15.
REQ-004 SHALL have parameter IO_BASE, default 8'hB0; page reg i at port low byte IO_BASE+i, control reg at IO_BASE+NWIN.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 reset  in  1  async active-high reset.
REQ-008 cpu_addr  in  16  Z80 address bus.
REQ-009 mreq_n, iorq_n, rd_n, wr_n  in  1 each  Z80 strobes, active low.
REQ-010 data_from_cpu  in  8  Z80 data out.
REQ-011 sram_sel  in  1  decoder says current memory cycle targets external SRAM.
REQ-012 ext_sram_addr  out  SRAM_AW  translated SRAM address.
REQ-013 sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low.
REQ-014 wait_n  out  1  Z80 wait request, active low.
REQ-015 data_to_cpu  out  8; data_to_cpu_oe  out  1  register readback.
REQ-016 wp_hit  out  1  one-cycle pulse on blocked write.

Function
REQ-017 Page reg i: bits[PAGE_W-1:0] page, bit 7 write-protect (WP); unused bits read 0.
REQ-018 Control reg: bit0 EN (mapping enable), bit1 LOCK; other bits read 0.
REQ-019 EN=0: ext_sram_addr = zero-extended cpu_addr (legacy identity map).
REQ-020 EN=1: ext_sram_addr = {page[w], cpu_addr[WIN_BITS-1:0]}, w = cpu_addr[15:WIN_BITS]; combinational, zero latency.
REQ-021 IO write detect: registered edge of (iorq_n=0 & wr_n=0); register updated exactly once per IO write cycle, on first clk where strobe seen, address low byte decoded.
REQ-022 LOCK=1: page reg writes ignored; control writes may still clear EN but not LOCK; LOCK cleared only by reset.
REQ-023 IO read (iorq_n=0, rd_n=0, matching port): data_to_cpu_oe=1 same cycle, data_to_cpu = register value; otherwise oe=0, data 8'h00.
REQ-024 Access FSM states IDLE, WAIT, DONE.
REQ-025 IDLE->WAIT when sram_sel=1 & mreq_n=0 & (rd_n=0 | wr_n=0); WAIT_CYCLES=0 goes IDLE->DONE directly.
REQ-026 WAIT: wait_n=0 for exactly WAIT_CYCLES clk cycles (counter), then ->DONE; wait_n=1 in IDLE and DONE.
REQ-027 DONE->IDLE when mreq_n=1; back-to-back cycles need mreq_n high for at least one clk between.
REQ-028 sram_oe_n = ~(sram_sel & ~mreq_n & ~rd_n), combinational.
REQ-029 sram_we_n = 0 only in WAIT/DONE with wr_n=0, sram_sel=1, and target window not WP (WP ignored when EN=0).
REQ-030 Write to WP window: sram_we_n held 1, wp_hit=1 for one clk on the IDLE exit, SRAM content untouched.
REQ-031 sram_sel dropping mid-access: FSM -> IDLE next clk, wait_n=1, sram_we_n=1.

Reset
REQ-032 On reset: page[i]=i, WP=0, EN=0, LOCK=0, FSM=IDLE, wait_n=1, sram_we_n=1, wp_hit=0, data_to_cpu_oe=0.
REQ-033 Reset mid-access SHALL immediately release wait_n and sram_we_n without waiting for a clock edge.

Verification
REQ-034 After reset, read at 16'h8123 with sram_sel=1 -> ext_sram_addr=21'h008123, wait_n low 2 clks.
REQ-035 OUT (B2),8'h25; OUT (B4),8'h01; read 16'h8123 -> ext_sram_addr=21'h094123; IN (B2) -> 8'h25.
REQ-036 OUT (B3),8'h85, EN=1, write 16'hC000 -> sram_we_n stays 1, wp_hit single pulse; read same address succeeds.
REQ-037 OUT (B4),8'h03 then OUT (B1),8'h10 -> IN (B1) still 8'h01; OUT (B4),8'h00 -> IN (B4)=8'h02, identity map restored.
REQ-038 WAIT_CYCLES=0 build: SRAM read -> wait_n never low; WAIT_CYCLES=15: wait_n low exactly 15 clks.
REQ-039 Assert reset during WAIT of a write -> wait_n=1, sram_we_n=1 asynchronously; all registers at REQ-032 values.

Source files
------------

// File: rtl/ace_sram_pager.sv
// Z80 memory pager for an external SRAM: IO-mapped page/control registers,
// window address translation, write protection and a wait-state access FSM.
module ace_sram_pager #(
  parameter int unsigned SRAM_AW     = 21,
  parameter int unsigned WIN_BITS    = 14,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  IO_BASE     = 8'hB0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        cpu_addr,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         data_from_cpu,
  input  logic               sram_sel,
  output logic [SRAM_AW-1:0] ext_sram_addr,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               wait_n,
  output logic [7:0]         data_to_cpu,
  output logic               data_to_cpu_oe,
  output logic               wp_hit
);

  localparam int unsigned WIN_W  = 16 - WIN_BITS;
  localparam int unsigned NWIN   = 2 ** WIN_W;
  localparam int unsigned PAGE_W = SRAM_AW - WIN_BITS;
  localparam logic [7:0]  NWIN8  = 8'(NWIN);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wp_hit_q, wp_hit_d;
  logic              io_wr_q, io_wr_d;
  logic [PAGE_W-1:0] page_q [NWIN];
  logic [PAGE_W-1:0] page_d [NWIN];
  logic [NWIN-1:0]   wp_q, wp_d;
  logic              en_q, en_d;
  logic              lock_q, lock_d;

  logic [WIN_W-1:0]  win;
  logic [7:0]        port_off;
  logic [WIN_W-1:0]  port_win;
  logic              hit_page, hit_ctrl;
  logic              io_wr, io_rd;
  logic              start, blocked, in_access;

  assign win      = cpu_addr[15:WIN_BITS];
  assign port_off = cpu_addr[7:0] - IO_BASE;
  assign port_win = port_off[WIN_W-1:0];
  assign hit_page = (port_off < NWIN8);
  assign hit_ctrl = (port_off == NWIN8);
  assign io_wr    = ~iorq_n & ~wr_n;
  assign io_rd    = ~iorq_n & ~rd_n;
  assign start    = sram_sel & ~mreq_n & (~rd_n | ~wr_n);
  assign blocked  = en_q & wp_q[win];

  // Register file: one update per IO write, taken on the strobe's first clock.
  always_comb begin
    page_d  = page_q;
    wp_d    = wp_q;
    en_d    = en_q;
    lock_d  = lock_q;
    io_wr_d = io_wr;
    if (io_wr && !io_wr_q) begin
      if (hit_page && !lock_q) begin
        page_d[port_win] = data_from_cpu[PAGE_W-1:0];
        wp_d[port_win]   = data_from_cpu[7];
      end else if (hit_ctrl) begin
        // Once locked, EN can only be cleared and LOCK stays set.
        en_d   = data_from_cpu[0] & (en_q | ~lock_q);
        lock_d = lock_q | data_from_cpu[1];
      end
    end
  end

  always_comb begin
    data_to_cpu    = '0;
    data_to_cpu_oe = 1'b0;
    if (io_rd && !reset && (hit_page || hit_ctrl)) begin
      data_to_cpu_oe = 1'b1;
      if (hit_page) begin
        data_to_cpu[PAGE_W-1:0] = page_q[port_win];
        data_to_cpu[7]          = wp_q[port_win];
      end else begin
        data_to_cpu[1:0] = {lock_q, en_q};
      end
    end
  end

  always_comb begin
    if (en_q) ext_sram_addr = {page_q[win], cpu_addr[WIN_BITS-1:0]};
    else      ext_sram_addr = SRAM_AW'(cpu_addr);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wp_hit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wp_hit_d = ~wr_n & blocked;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!sram_sel)         state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_DONE;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        if (!sram_sel || mreq_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are also gated by reset so they release before any clock edge.
  assign in_access = (state_q == S_WAIT) || (state_q == S_DONE);
  assign wait_n    = ~((state_q == S_WAIT) & sram_sel & ~reset);
  assign sram_we_n = ~(in_access & ~wr_n & sram_sel & ~blocked & ~reset);
  assign sram_oe_n = ~(sram_sel & ~mreq_n & ~rd_n);
  assign wp_hit    = wp_hit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wp_hit_q <= 1'b0;
      io_wr_q  <= 1'b0;
      wp_q     <= '0;
      en_q     <= 1'b0;
      lock_q   <= 1'b0;
      for (int unsigned i = 0; i < NWIN; i++) page_q[i] <= PAGE_W'(i);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wp_hit_q <= wp_hit_d;
      io_wr_q  <= io_wr_d;
      wp_q     <= wp_d;
      en_q     <= en_d;
      lock_q   <= lock_d;
      page_q   <= page_d;
    end
  end

endmodule

// File: tb/tb_ace_sram_pager.sv
// Bench for ace_sram_pager: directed Z80 IO/memory cycles, checked against a
// transaction-level model every cycle plus literal expectations.
module tb_ace_sram_pager;
  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  data_from_cpu = '0;
  logic        sram_sel = 1'b0;

  logic [20:0] ext_sram_addr, ext0, ext15;
  logic        sram_oe_n, sram_we_n, wait_n, data_to_cpu_oe, wp_hit;
  logic        oe0, we0, wait_n0, doe0, wp0, oe15, we15, wait_n15, doe15, wp15;
  logic [7:0]  data_to_cpu, d0, d15;

  int checks = 0;
  int errors = 0;

  ace_sram_pager #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .data_from_cpu(data_from_cpu), .sram_sel(sram_sel),
    .ext_sram_addr(ext_sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .wait_n(wait_n), .data_to_cpu(data_to_cpu), .data_to_cpu_oe(data_to_cpu_oe), .wp_hit(wp_hit));

  ace_sram_pager #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .data_from_cpu(data_from_cpu), .sram_sel(sram_sel),
    .ext_sram_addr(ext0), .sram_oe_n(oe0), .sram_we_n(we0),
    .wait_n(wait_n0), .data_to_cpu(d0), .data_to_cpu_oe(doe0), .wp_hit(wp0));

  ace_sram_pager #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .data_from_cpu(data_from_cpu), .sram_sel(sram_sel),
    .ext_sram_addr(ext15), .sram_oe_n(oe15), .sram_we_n(we15),
    .wait_n(wait_n15), .data_to_cpu(d15), .data_to_cpu_oe(doe15), .wp_hit(wp15));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: register file and access age (clock edges since the access started).
  int m_page[4];
  int m_wp[4];
  int m_en, m_lock, m_io_prev, m_active, m_age, m_wpflag;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_page[i] = i; m_wp[i] = 0; end
    m_en = 0; m_lock = 0; m_io_prev = 0; m_active = 0; m_age = 0; m_wpflag = 0;
  endtask

  task automatic model_step();
    int p, w, io_now;
    w = cpu_addr / 16384;
    if (m_active != 0) begin
      if (!sram_sel) m_active = 0;
      else if (m_age > MW && mreq_n) m_active = 0;
      else m_age++;
    end else if (sram_sel && !mreq_n && (!rd_n || !wr_n)) begin
      m_active = 1;
      m_age = 1;
      m_wpflag = (!wr_n && m_en != 0 && m_wp[w] != 0) ? 1 : 0;
    end
    io_now = (!iorq_n && !wr_n) ? 1 : 0;
    if (io_now != 0 && m_io_prev == 0) begin
      p = int'(cpu_addr[7:0]) - 176;
      if (p >= 0 && p < 4 && m_lock == 0) begin
        m_page[p] = data_from_cpu % 128;
        m_wp[p]   = data_from_cpu / 128;
      end else if (p == 4) begin
        if (m_lock != 0) m_en = (m_en != 0 && data_from_cpu[0]) ? 1 : 0;
        else m_en = data_from_cpu[0];
        if (data_from_cpu[1]) m_lock = 1;
      end
    end
    m_io_prev = io_now;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      int w, p, e_addr, e_oe, e_data, e_we, e_wait, e_wp;
      w = cpu_addr / 16384;
      p = int'(cpu_addr[7:0]) - 176;
      e_addr = (m_en != 0) ? m_page[w] * 16384 + (cpu_addr % 16384) : cpu_addr;
      e_oe = (!iorq_n && !rd_n && p >= 0 && p <= 4) ? 1 : 0;
      e_data = 0;
      if (e_oe != 0) e_data = (p < 4) ? m_wp[p] * 128 + m_page[p] : m_lock * 2 + m_en;
      e_wait = (m_active != 0 && m_age <= MW && sram_sel) ? 0 : 1;
      e_we = (m_active != 0 && !wr_n && sram_sel && !(m_en != 0 && m_wp[w] != 0)) ? 0 : 1;
      e_wp = (m_active != 0 && m_age == 1 && m_wpflag != 0) ? 1 : 0;
      chk("addr", 32'(ext_sram_addr), 32'(e_addr));
      chk("oe_n", 32'(sram_oe_n), 32'(!(sram_sel && !mreq_n && !rd_n)));
      chk("we_n", 32'(sram_we_n), 32'(e_we));
      chk("wait_n", 32'(wait_n), 32'(e_wait));
      chk("wp_hit", 32'(wp_hit), 32'(e_wp));
      chk("rd_oe", 32'(data_to_cpu_oe), 32'(e_oe));
      chk("rd_data", 32'(data_to_cpu), 32'(e_data));
      chk("wait_n_w0", 32'(wait_n0), 32'd1);
    end
  end

  int n_wait = 0, n_wait15 = 0, n_wp = 0, n_we = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (!wait_n)    n_wait   <= n_wait + 1;
      if (!wait_n15)  n_wait15 <= n_wait15 + 1;
      if (wp_hit)     n_wp     <= n_wp + 1;
      if (!sram_we_n) n_we     <= n_we + 1;
    end
  end

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = {8'h00, port}; data_from_cpu = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic io_read(input string name, input logic [7:0] port, input logic [7:0] exp);
    @(posedge clk); #1;
    cpu_addr = {8'h00, port}; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk(name, 32'(data_to_cpu), 32'(exp));
    chk({name, "_oe"}, 32'(data_to_cpu_oe), 32'd1);
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b0; rd_n = 1'b1;
  endtask

  task automatic mem_acc(input logic [15:0] a, input bit wr, input int hold,
                         output logic [20:0] addr_seen, output int dw, output int dw15,
                         output int dwp, output int dwe);
    int s_w, s_w15, s_wp, s_we;
    @(posedge clk); #1;
    s_w = n_wait; s_w15 = n_wait15; s_wp = n_wp; s_we = n_we;
    cpu_addr = a; data_from_cpu = 8'h3C; sram_sel = 1'b1; mreq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    @(negedge clk);
    addr_seen = ext_sram_addr;
    repeat (hold) @(posedge clk);
    #1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; sram_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dw = n_wait - s_w; dw15 = n_wait15 - s_w15; dwp = n_wp - s_wp; dwe = n_we - s_we;
  endtask

  initial begin
    logic [20:0] a;
    int dw, dw15, dwp, dwe;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_wp_hit", 32'(wp_hit), 32'd0);
    reset = 1'b0;

    mem_acc(16'h8123, 1'b0, 4, a, dw, dw15, dwp, dwe);
    chk("ident_addr", 32'(a), 32'h008123);
    chk("ident_wait", 32'(dw), 32'd2);

    io_write(8'hB2, 8'h25);
    io_write(8'hB4, 8'h01);
    mem_acc(16'h8123, 1'b0, 4, a, dw, dw15, dwp, dwe);
    chk("map_addr", 32'(a), 32'h094123);
    io_read("in_b2", 8'hB2, 8'h25);
    io_read("in_b4", 8'hB4, 8'h01);

    io_write(8'hB3, 8'h85);
    mem_acc(16'hC000, 1'b1, 4, a, dw, dw15, dwp, dwe);
    chk("wp_we_cnt", 32'(dwe), 32'd0);
    chk("wp_pulse", 32'(dwp), 32'd1);
    mem_acc(16'hC000, 1'b0, 4, a, dw, dw15, dwp, dwe);
    chk("wp_rd_addr", 32'(a), 32'h014000);
    chk("wp_rd_wait", 32'(dw), 32'd2);

    io_write(8'hB4, 8'h03);
    io_write(8'hB1, 8'h10);
    io_read("lock_b1", 8'hB1, 8'h01);
    io_write(8'hB4, 8'h00);
    io_read("lock_b4", 8'hB4, 8'h02);
    mem_acc(16'h8123, 1'b0, 4, a, dw, dw15, dwp, dwe);
    chk("unmap_addr", 32'(a), 32'h008123);
    mem_acc(16'hC000, 1'b1, 4, a, dw, dw15, dwp, dwe);
    chk("wp_off_we", 32'(dwe), 32'd3);
    chk("wp_off_pulse", 32'(dwp), 32'd0);

    @(posedge clk); #1;
    cpu_addr = 16'hB5; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("nomatch_oe", 32'(data_to_cpu_oe), 32'd0);
    chk("nomatch_data", 32'(data_to_cpu), 32'd0);
    @(posedge clk); #1; iorq_n = 1'b1; rd_n = 1'b1;

    mem_acc(16'h0200, 1'b0, 17, a, dw, dw15, dwp, dwe);
    chk("w15_wait", 32'(dw15), 32'd15);
    chk("w2_wait", 32'(dw), 32'd2);

    @(posedge clk); #1;
    cpu_addr = 16'h0010; sram_sel = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    dw = n_wait;
    sram_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1; mreq_n = 1'b1; rd_n = 1'b1;
    chk("seldrop_wait", 32'(n_wait - dw), 32'd0);
    repeat (2) @(posedge clk);

    @(posedge clk); #1;
    cpu_addr = 16'h4000; data_from_cpu = 8'h5A; sram_sel = 1'b1; mreq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_wait", 32'(wait_n), 32'd0);
    chk("pre_rst_we", 32'(sram_we_n), 32'd0);
    #2; reset = 1'b1;
    #1;
    chk("async_wait", 32'(wait_n), 32'd1);
    chk("async_we", 32'(sram_we_n), 32'd1);
    mreq_n = 1'b1; wr_n = 1'b1; sram_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    io_read("post_b0", 8'hB0, 8'h00);
    io_read("post_b1", 8'hB1, 8'h01);
    io_read("post_b2", 8'hB2, 8'h02);
    io_read("post_b3", 8'hB3, 8'h03);
    io_read("post_b4", 8'hB4, 8'h00);
    io_write(8'hB1, 8'h11);
    io_read("unlock_b1", 8'hB1, 8'h11);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
